if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined CPU. It owns the PC and drives a request/acknowledge port to the instruction memory controller. It presents `{pc_o, inst_o}` to the decode stage and applies decode's branch redirect after exactly one delay slot. It absorbs memory wait states, pipeline stalls and controller flushes.

---
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit CPU.
// Owns the PC, fetches over a req/ack port and applies decode's redirect after one delay slot.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [15:0] flush_addr_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o
);

    localparam int unsigned XLEN = 16;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   hold_q, hold_d;
    logic              pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    logic [XLEN-1:0]   inst_q, inst_d;

    logic [XLEN-1:0]   pc_inc_c;
    logic [XLEN-1:0]   next_pc_c;
    logic              branch_ok_c;
    logic              deliver_c;
    logic [XLEN-1:0]   deliver_word_c;

    // Sequential PC increment wraps naturally at 16 bits.
    assign pc_inc_c    = pc_q + XLEN'(1);
    // A redirect from decode only counts on an un-stalled cycle.
    assign branch_ok_c = branch_flag_i & ~stall_i;

    // PC after a delivery: a pending redirect beats a fresh one, which beats sequential.
    always_comb begin
        next_pc_c = pc_inc_c;
        if (pend_valid_q) begin
            next_pc_c = pend_addr_q;
        end else if (branch_ok_c) begin
            next_pc_c = branch_addr_i;
        end
    end

    // Fetch control, IF/ID update and redirect bookkeeping.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        pend_valid_d   = pend_valid_q;
        pend_addr_d    = pend_addr_q;
        pc_out_d       = pc_out_q;
        inst_d         = inst_q;
        deliver_c      = 1'b0;
        deliver_word_c = hold_q;

        if (flush_i) begin
            pc_out_d     = flush_addr_i;
            inst_d       = NOP_INST;
            pc_d         = flush_addr_i;
            pend_valid_d = 1'b0;
            state_d      = ST_REQ;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ack_i) begin
                        if (stall_i) begin
                            // Park the returned word; it is never re-requested.
                            hold_d  = imem_data_i;
                            state_d = ST_HELD;
                        end else begin
                            deliver_c      = 1'b1;
                            deliver_word_c = imem_data_i;
                        end
                    end else if (!stall_i) begin
                        // Wait state: push one bubble, keep fetching the same PC.
                        pc_out_d = pc_inc_c;
                        inst_d   = NOP_INST;
                    end
                end
                ST_HELD: begin
                    if (!stall_i) begin
                        deliver_c      = 1'b1;
                        deliver_word_c = hold_q;
                        state_d        = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase

            if (deliver_c) begin
                pc_out_d     = pc_inc_c;
                inst_d       = deliver_word_c;
                pc_d         = next_pc_c;
                pend_valid_d = 1'b0;
            end else if (branch_ok_c && !pend_valid_q) begin
                // Delay slot not delivered yet: remember the target until it is.
                pend_valid_d = 1'b1;
                pend_addr_d  = branch_addr_i;
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            hold_q       <= NOP_INST;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pc_out_q     <= '0;
            inst_q       <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pc_out_q     <= pc_out_d;
            inst_q       <= inst_d;
        end
    end

    // Request is suppressed during reset so an in-flight fetch is abandoned.
    assign imem_req_o  = rst & (state_q == ST_REQ);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_out_q;
    assign inst_o      = inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: spec-level model plus directed literal checks.
module tb_if_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_flag_i, imem_ack_i;
    logic [15:0] flush_addr_i, branch_addr_i, imem_data_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o, pc_o, inst_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    // Model of the architectural state.
    logic [15:0] m_pc, m_hold, m_pend_a, m_pco, m_inst;
    logic        m_held, m_pend_v;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .branch_flag_i(branch_flag_i),
        .branch_addr_i(branch_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_held = 1'b0; m_hold = NOP;
        m_pend_v = 1'b0; m_pend_a = 16'h0000;
        m_pco = 16'h0000; m_inst = NOP;
    endtask

    // One clock edge of the fetch stage, described as instruction events.
    task automatic model_step();
        logic        got;
        logic [15:0] word;
        got = 1'b0;
        word = 16'h0000;
        if (!rst) begin
            model_reset();
        end else if (flush_i) begin
            m_pco = flush_addr_i; m_inst = NOP; m_pc = flush_addr_i;
            m_pend_v = 1'b0; m_held = 1'b0;
        end else if (m_held) begin
            if (!stall_i) begin got = 1'b1; word = m_hold; end
        end else if (imem_ack_i) begin
            if (stall_i) begin m_held = 1'b1; m_hold = imem_data_i; end
            else begin got = 1'b1; word = imem_data_i; end
        end else if (!stall_i) begin
            m_pco = m_pc + 16'd1; m_inst = NOP;
            if (branch_flag_i && !m_pend_v) begin m_pend_v = 1'b1; m_pend_a = branch_addr_i; end
        end
        if (got) begin
            m_pco  = m_pc + 16'd1;
            m_inst = word;
            if (m_pend_v)           m_pc = m_pend_a;
            else if (branch_flag_i) m_pc = branch_addr_i;
            else                    m_pc = m_pc + 16'd1;
            m_pend_v = 1'b0;
            m_held   = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req",  {15'b0, imem_req_o}, {15'b0, rst & ~m_held});
            chk("addr", imem_addr_o, m_pc);
            chk("pc_o", pc_o, m_pco);
            chk("inst", inst_o, m_inst);
        end
    end

    // Apply inputs for one edge; memory returns 0x1000+addr.
    task automatic cyc(input logic ack, input logic stall, input logic br, input logic [15:0] baddr,
                       input logic fl, input logic [15:0] faddr);
        imem_ack_i    = ack;
        imem_data_i   = 16'h1000 + imem_addr_o;
        stall_i       = stall;
        branch_flag_i = br;
        branch_addr_i = baddr;
        flush_i       = fl;
        flush_addr_i  = faddr;
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
        imem_ack_i = 1'b1; imem_data_i = 16'h1234;
        flush_addr_i = 16'h0; branch_addr_i = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst pc_o", pc_o, 16'h0000);
        chk("rst inst", inst_o, 16'h0800);
        chk("rst req", {15'b0, imem_req_o}, 16'h0000);
        rst = 1'b1;
        #1;
        chk("post-rst addr", imem_addr_o, 16'h0000);
        chk("post-rst req", {15'b0, imem_req_o}, 16'h0001);

        // Streaming
        cyc(1, 0, 0, 0, 0, 0);
        chk("s0 inst", inst_o, 16'h1000); chk("s0 pc", pc_o, 16'h0001);
        cyc(1, 0, 0, 0, 0, 0);
        chk("s1 inst", inst_o, 16'h1001); chk("s1 pc", pc_o, 16'h0002);
        cyc(1, 0, 0, 0, 0, 0);
        chk("s2 inst", inst_o, 16'h1002); chk("s2 pc", pc_o, 16'h0003);

        // Wait states: ack every third cycle
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("w bubble", inst_o, 16'h0800);
            chk("w addr", imem_addr_o, 16'h0003 + 16'(k));
            cyc(0, 0, 0, 0, 0, 0);
            chk("w bubble2", inst_o, 16'h0800);
            cyc(1, 0, 0, 0, 0, 0);
            chk("w inst", inst_o, 16'h1003 + 16'(k));
        end

        // Stall at ack of 0x0007
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pre-stall addr", imem_addr_o, 16'h0007);
        cyc(1, 1, 0, 0, 0, 0);
        chk("stall1 req", {15'b0, imem_req_o}, 16'h0000);
        chk("stall1 inst", inst_o, 16'h1006);
        cyc(1, 1, 0, 0, 0, 0);
        chk("stall2 req", {15'b0, imem_req_o}, 16'h0000);
        chk("stall2 pc", pc_o, 16'h0007);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rel inst", inst_o, 16'h1007);
        chk("rel pc", pc_o, 16'h0008);
        chk("rel addr", imem_addr_o, 16'h0008);

        // Stream up to the delay slot at 0x0011, branch on its ack
        repeat (9) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 16'h0040, 0, 0);
        chk("br inst", inst_o, 16'h1011);
        chk("br addr", imem_addr_o, 16'h0040);

        // Delayed delay slot; second branch while pending is ignored
        cyc(0, 0, 0, 0, 1, 16'h0011);
        chk("fl11 pc", pc_o, 16'h0011);
        cyc(0, 0, 1, 16'h0040, 0, 0);
        cyc(0, 0, 1, 16'h0099, 0, 0);
        chk("dly addr", imem_addr_o, 16'h0011);
        cyc(1, 0, 0, 0, 0, 0);
        chk("dly inst", inst_o, 16'h1011);
        chk("dly pc", pc_o, 16'h0012);
        chk("dly addr2", imem_addr_o, 16'h0040);

        // Flush while HELD with a pending redirect
        cyc(0, 0, 1, 16'h0070, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("held req", {15'b0, imem_req_o}, 16'h0000);
        cyc(1, 1, 0, 0, 1, 16'h0005);
        chk("fl inst", inst_o, 16'h0800);
        chk("fl pc", pc_o, 16'h0005);
        chk("fl addr", imem_addr_o, 16'h0005);
        chk("fl req", {15'b0, imem_req_o}, 16'h0001);
        cyc(1, 0, 0, 0, 0, 0);
        chk("fl next inst", inst_o, 16'h1005);
        chk("fl next addr", imem_addr_o, 16'h0006);

        // PC wrap
        cyc(0, 0, 0, 0, 1, 16'hFFFF);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wrap inst", inst_o, 16'h0FFF);
        chk("wrap pc", pc_o, 16'h0000);
        chk("wrap addr", imem_addr_o, 16'h0000);

        // Reset asserted mid-fetch
        cyc(1, 0, 0, 0, 0, 0);
        imem_ack_i = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid-rst req", {15'b0, imem_req_o}, 16'h0000);
        chk("mid-rst inst", inst_o, 16'h0800);
        chk("mid-rst pc", pc_o, 16'h0000);
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
